i2c_codec_init: RTL and testbench

Configures the board audio codec over I2C once after reset, then hands the two shared pins over to LED drive and button sensing. It sits in the top level beside the I2S transmitter: `scl_led` is I2C SCL and the user LED, and `sda_btn` is I2C SDA and the user button. Both pins are open-drain with external pull-ups. The block emits a fixed table of register writes, retries any transaction that is NACKed, and then asserts `done`.

---
 rtl/i2c_codec_init.sv | 197 +++++++++++++++++++
 tb/tb_i2c_codec_init.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_init.sv
// rtl/i2c_codec_init.sv - one-shot I2C codec register loader that hands its pins to an LED and a button
module i2c_codec_init #(
    parameter int         CLK_DIV  = 30,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic clk,
    input  logic rst,
    inout  wire  scl_led,
    inout  wire  sda_btn,
    input  logic led,
    output logic btn,
    output logic done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [2:0] LAST_ENTRY = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE_WAIT,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [2:0]       entry_q, entry_d;
    logic             nack_q, nack_d;
    logic             scl_drv_q, scl_drv_d;
    logic             sda_drv_q, sda_drv_d;
    logic             done_q, done_d;
    logic [1:0]       sync_q;
    logic [15:0]      word;
    logic [7:0]       cur_byte;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        case (entry_q)
            3'd0:    word = 16'h1E00;
            3'd1:    word = 16'h0C00;
            3'd2:    word = 16'h0E02;
            3'd3:    word = 16'h1000;
            3'd4:    word = 16'h0812;
            3'd5:    word = 16'h0A00;
            default: word = 16'h1201;
        endcase
    end

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        entry_d   = entry_q;
        nack_d    = nack_q;
        scl_drv_d = scl_drv_q;
        sda_drv_d = sda_drv_q;
        done_d    = done_q;
        if (tick) begin
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                S_IDLE_WAIT: begin
                    scl_drv_d = 1'b0;
                    sda_drv_d = 1'b0;
                    if (qtr_q == 2'd3) begin
                        state_d = S_START;
                        qtr_d   = 2'd0;
                    end
                end
                S_START: begin
                    if (qtr_q == 2'd0) begin
                        sda_drv_d = 1'b1;
                    end else begin
                        scl_drv_d = 1'b1;
                        state_d   = S_BIT;
                        qtr_d     = 2'd0;
                        bit_d     = 3'd7;
                        byte_d    = 2'd0;
                        nack_d    = 1'b0;
                    end
                end
                S_BIT: begin
                    case (qtr_q)
                        2'd0: sda_drv_d = ~cur_byte[bit_q];
                        2'd1: scl_drv_d = 1'b0;
                        2'd2: ;
                        default: begin
                            scl_drv_d = 1'b1;
                            if (bit_q == 3'd0) state_d = S_ACK;
                            else bit_d = bit_q - 3'd1;
                        end
                    endcase
                end
                S_ACK: begin
                    case (qtr_q)
                        2'd0: sda_drv_d = 1'b0;
                        2'd1: scl_drv_d = 1'b0;
                        // released SDA reads high through the pull-up: NACK
                        2'd2: nack_d = nack_q | sync_q[1];
                        default: begin
                            scl_drv_d = 1'b1;
                            if (nack_q || byte_q == 2'd2) begin
                                state_d = S_STOP;
                                qtr_d   = 2'd0;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                state_d = S_BIT;
                            end
                        end
                    endcase
                end
                S_STOP: begin
                    case (qtr_q)
                        2'd0: sda_drv_d = 1'b1;
                        2'd1: scl_drv_d = 1'b0;
                        default: begin
                            sda_drv_d = 1'b0;
                            state_d   = S_GAP;
                            qtr_d     = 2'd0;
                        end
                    endcase
                end
                S_GAP: begin
                    if (qtr_q == 2'd3) begin
                        qtr_d = 2'd0;
                        if (nack_q) begin
                            state_d = S_START;
                        end else if (entry_q == LAST_ENTRY) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            entry_d = entry_q + 3'd1;
                            state_d = S_START;
                        end
                    end
                end
                S_DONE: begin
                    scl_drv_d = 1'b0;
                    sda_drv_d = 1'b0;
                    qtr_d     = 2'd0;
                end
                default: state_d = S_IDLE_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            state_q   <= S_IDLE_WAIT;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            byte_q    <= 2'd0;
            entry_q   <= 3'd0;
            nack_q    <= 1'b0;
            scl_drv_q <= 1'b0;
            sda_drv_q <= 1'b0;
            done_q    <= 1'b0;
            sync_q    <= 2'b11;
        end else begin
            div_q     <= tick ? '0 : div_q + DIV_W'(1);
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            entry_q   <= entry_d;
            nack_q    <= nack_d;
            scl_drv_q <= scl_drv_d;
            sda_drv_q <= sda_drv_d;
            done_q    <= done_d;
            sync_q    <= {sync_q[0], sda_btn};
        end
    end

    // once configured, SCL becomes the open-drain LED output
    assign scl_led = (done_q ? led : scl_drv_q) ? 1'b0 : 1'bz;
    assign sda_btn = sda_drv_q ? 1'b0 : 1'bz;
    assign btn     = done_q & ~sync_q[1];
    assign done    = done_q;
endmodule

// File: tb/tb_i2c_codec_init.sv
// tb/tb_i2c_codec_init.sv - I2C decoding slave, timing model and pin checks for i2c_codec_init
module tb_i2c_codec_init;
    localparam int DIV = 4;
    localparam logic [7:0] ADDR_W = {7'h1A, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic rst_q = 1'b1;
    logic led = 1'b0;
    logic btn, done;
    logic slave_ack = 1'b0;
    logic btn_pull = 1'b0;
    wire  scl_w, sda_w;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = ((slave_ack && !rst) || btn_pull) ? 1'b0 : 1'bz;

    i2c_codec_init #(.CLK_DIV(DIV), .DEV_ADDR(7'h1A)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_led (scl_w),
        .sda_btn (sda_w),
        .led     (led),
        .btn     (btn),
        .done    (done)
    );

    always @(posedge clk) rst_q <= rst;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ok(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: expected transaction list and expected done time
    logic [15:0] tbl [7] = '{16'h1E00, 16'h0C00, 16'h0E02, 16'h1000, 16'h0812, 16'h0A00, 16'h1201};
    int n_exp;
    int exp_len [8];
    logic [7:0] exp_b [8][3];
    int q_exp = 823;

    task automatic build(input int nack_entry);
        int idx;
        logic [15:0] w;
        idx = 0;
        for (int e = 0; e < 7; e++) begin
            w = tbl[e];
            if (e == nack_entry) begin
                exp_len[idx] = 1;
                exp_b[idx][0] = ADDR_W;
                exp_b[idx][1] = 8'h00;
                exp_b[idx][2] = 8'h00;
                idx++;
            end
            exp_len[idx] = 3;
            exp_b[idx][0] = ADDR_W;
            exp_b[idx][1] = w[15:8];
            exp_b[idx][2] = w[7:0];
            idx++;
        end
        n_exp = idx;
    endtask

    function automatic int qtot(input int nack_entry);
        int q;
        q = 4 + 7 * (2 + 27 * 4 + 3 + 4);
        if (nack_entry >= 0) q += 2 + 9 * 4 + 3 + 4;
        return q;
    endfunction

    // bus monitor / slave state
    logic pscl = 1'b1, psda = 1'b1, c, s, led_p = 1'b0;
    logic [3:0] sda_h = 4'hF;
    logic [7:0] sh;
    logic [7:0] rxb [3];
    int cyc = 0, bitcnt = 0, nbytes = 0, txn_idx = 0, in_txn = 0, have_bit = 0, cur_bit = 0;
    int done_cyc = -1;
    bit mute = 1'b0;

    always @(negedge clk) begin
        c = scl_w;
        s = sda_w;
        sda_h = {sda_h[2:0], s};
        if (rst_q) begin
            cyc = 0; done_cyc = -1; slave_ack = 1'b0;
            in_txn = 0; bitcnt = 0; nbytes = 0; txn_idx = 0; have_bit = 0;
        end else begin
            cyc++;
            if (cyc < (q_exp - 1) * DIV) begin
                chk("done_early", {31'd0, done}, 32'd0);
                chk("btn_pre_done", {31'd0, btn}, 32'd0);
            end
            if (cyc >= (q_exp + 1) * DIV) chk("done_late", {31'd0, done}, 32'd1);
            if (done && done_cyc < 0) done_cyc = cyc;
            if (cyc >= (q_exp + 1) * DIV + 4) begin
                chk_ok("btn_follow", (btn == ~sda_h[2]) || (btn == ~sda_h[3]), {31'd0, btn}, {31'd0, ~sda_h[2]});
                chk_ok("scl_led_follow", (c == ~led) || (c == ~led_p), {31'd0, c}, {31'd0, ~led});
                chk("sda_released", {31'd0, s}, {31'd0, ~btn_pull});
            end
            if (!mute && cyc < (q_exp - 1) * DIV) begin
                if (pscl && c && psda != s) begin
                    have_bit = 0;
                    if (!s) begin
                        chk("start_outside_txn", in_txn, 0);
                        in_txn = 1; bitcnt = 0; nbytes = 0;
                        rxb[0] = 8'h00; rxb[1] = 8'h00; rxb[2] = 8'h00;
                    end else begin
                        chk("stop_in_txn", in_txn, 1);
                        chk("stop_on_boundary", bitcnt, 0);
                        if (txn_idx < n_exp)
                            chk("txn_bytes", {nbytes[7:0], rxb[0], rxb[1], rxb[2]},
                                {exp_len[txn_idx][7:0], exp_b[txn_idx][0], exp_b[txn_idx][1], exp_b[txn_idx][2]});
                        else
                            chk("txn_extra", txn_idx, n_exp - 1);
                        txn_idx++;
                        in_txn = 0;
                    end
                end else if (!pscl && c && in_txn != 0) begin
                    cur_bit = int'(s);
                    have_bit = 1;
                end else if (pscl && !c && in_txn != 0 && have_bit != 0) begin
                    have_bit = 0;
                    bitcnt++;
                    if (bitcnt <= 8) sh = {sh[6:0], cur_bit[0]};
                    if (bitcnt == 8) begin
                        if (nbytes < 3) rxb[nbytes] = sh;
                        nbytes++;
                        slave_ack = !(txn_idx < n_exp && exp_len[txn_idx] == 1);
                    end else if (bitcnt == 9) begin
                        slave_ack = 1'b0;
                        bitcnt = 0;
                    end
                end
            end
        end
        pscl = c;
        psda = s;
        led_p = led;
    end

    task automatic wait_done(input bit rand_led);
        for (int i = 0; i < (q_exp + 3) * DIV + 20 && !done; i++) begin
            @(posedge clk); #1;
            if (rand_led) led = 1'($urandom % 2);
        end
        chk("done_reached", {31'd0, done}, 32'd1);
        @(negedge clk); #1;
        chk_ok("done_time", done_cyc >= (q_exp - 1) * DIV && done_cyc <= (q_exp + 1) * DIV, done_cyc, q_exp * DIV);
        chk("txn_count", txn_idx, n_exp);
    endtask

    task automatic btn_latency(input logic pull, input string name);
        int lat;
        @(posedge clk); #1;
        btn_pull = pull;
        lat = 99;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (btn == pull) begin lat = k; break; end
        end
        chk_ok(name, lat <= 3, lat, 3);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        build(-1);
        q_exp = qtot(-1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scl", {31'd0, scl_w}, 32'd1);
        chk("reset_sda", {31'd0, sda_w}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_btn", {31'd0, btn}, 32'd0);
        chk("model_q_free", qtot(-1), 823);
        chk("model_n_exp", n_exp, 7);
        chk("model_txn4", {8'd0, exp_b[4][0], exp_b[4][1], exp_b[4][2]}, 32'h00340812);

        // run 1: fault-free, LED toggled and button pulled before done
        rst = 1'b0;
        @(posedge clk); #1;
        mute = 1'b1; btn_pull = 1'b1; led = 1'b1;
        repeat (6) @(posedge clk);
        #1 btn_pull = 1'b0;
        repeat (2) @(posedge clk);
        #1 mute = 1'b0;
        wait_done(1'b1);

        repeat (10) @(posedge clk);
        #1 led = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("led0_scl", {31'd0, scl_w}, 32'd1);
        @(posedge clk); #1 led = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("led1_scl", {31'd0, scl_w}, 32'd0);
        @(posedge clk); #1 led = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk("led0_again_scl", {31'd0, scl_w}, 32'd1);
        btn_latency(1'b1, "btn_press_latency");
        repeat (7) @(posedge clk);
        btn_latency(1'b0, "btn_release_latency");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            btn_pull = 1'($urandom % 2);
            led = 1'($urandom % 2);
            repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        #1 btn_pull = 1'b0;
        repeat (5) @(posedge clk);

        // run 2: NACK on the address byte of entry 3, once
        #1 rst = 1'b1; led = 1'b0;
        @(posedge clk); #1;
        build(3);
        q_exp = qtot(3);
        chk("model_q_nack", q_exp, 868);
        chk("model_n_exp_nack", n_exp, 8);
        chk("model_len3", exp_len[3], 1);
        @(posedge clk); #1 rst = 1'b0;
        wait_done(1'b0);

        // run 3: reset pulse in the middle of transaction 2
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        build(-1);
        q_exp = qtot(-1);
        @(posedge clk); #1 rst = 1'b0;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (txn_idx == 2 && in_txn != 0) begin ok = 1; break; end
        end
        chk("txn2_started", ok, 1);
        repeat ($urandom_range(5, 400)) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_scl_released", {31'd0, scl_w}, 32'd1);
        chk("rst_sda_released", {31'd0, sda_w}, 32'd1);
        chk("rst_done_low", {31'd0, done}, 32'd0);
        rst = 1'b0;
        wait_done(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
